// File: rtl/turing_board_pkg.sv
// turing_board_pkg: shared colour constants, board state enum and trigger priority encoder
package turing_board_pkg;
    localparam int BLUE = 0;
    localparam int RED  = 1;

    typedef enum logic [1:0] {START, RUN, HALT} state_e;

    // Lowest set bit wins; result is {found, index[2:0]} for up to eight levers
    function automatic logic [3:0] prio_enc(input logic [7:0] v);
        prio_enc = 4'b0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) prio_enc = {1'b1, 3'(i)};
    endfunction
endpackage

// File: rtl/turing_hopper.sv
// turing_hopper: per-colour ball counter that reloads to full and counts down to empty
module turing_hopper #(
    parameter int BALLS_PER_COLOR = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic empty_o
);
    logic [4:0] cnt_q, cnt_d;

    // Reload wins over a release; an empty hopper stays at zero
    always_comb begin
        cnt_d = load_i ? 5'(BALLS_PER_COLOR) : (dec_i && cnt_q != 5'd0) ? cnt_q - 5'd1 : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 5'(BALLS_PER_COLOR);
        else     cnt_q <= cnt_d;
    end

    assign empty_o = cnt_q == 5'd0;
endmodule

// File: rtl/turing_board_gen.sv
// turing_board_gen: hoppers, ball release, current-colour tracking and finished-ball tray
module turing_board_gen
    import turing_board_pkg::*;
#(
    parameter int NUM_COLORS      = 2,
    parameter int BALLS_PER_COLOR = 8,
    parameter int TRAY_DEPTH      = 16,
    parameter int CW              = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_COLORS-1:0]        trigger,
    input  logic                         reload,
    output logic                         ball_valid,
    output logic [CW-1:0]                ball_color,
    output logic [CW-1:0]                current_color,
    output logic                         no_balls,
    output logic [TRAY_DEPTH*CW-1:0]     tray,
    output logic [$clog2(TRAY_DEPTH+1)-1:0] tray_count,
    output logic                         tray_full,
    output logic                         tray_overflow
);
    localparam int TW = $clog2(TRAY_DEPTH + 1);

    state_e                  state_q, state_d;
    logic [3:0]              enc;
    logic                    found, acc, rel, app;
    logic [CW-1:0]           c;
    logic [NUM_COLORS-1:0]   empty;
    logic                    ball_valid_q, ball_valid_d;
    logic [CW-1:0]           ball_color_q, ball_color_d;
    logic [CW-1:0]           current_color_q, current_color_d;
    logic                    no_balls_q, no_balls_d;
    logic                    tray_overflow_q, tray_overflow_d;
    logic [TW-1:0]           tray_count_q, tray_count_d;
    logic [TRAY_DEPTH*CW-1:0] tray_q, tray_d;

    assign enc   = prio_enc(8'(trigger));
    assign found = enc[3];
    assign c     = CW'(enc[2:0]);

    for (genvar h = 0; h < NUM_COLORS; h++) begin : g_hop
        turing_hopper #(.BALLS_PER_COLOR(BALLS_PER_COLOR)) u_hop (
            .clk     (clk),
            .rst     (rst),
            .load_i  (reload),
            .dec_i   (rel && c == CW'(h)),
            .empty_o (empty[h])
        );
    end

    // Accept the lowest lever unless halted or reloading; append the finished ball only while running
    always_comb begin
        acc     = found && state_q != HALT && !reload;
        rel     = acc && !empty[c];
        app     = acc && state_q == RUN;
        state_d = reload ? START : rel ? RUN : acc ? HALT : state_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= START;
        else     state_q <= state_d;
    end

    // Datapath next state: release outputs, sticky flags and tray append without wrap
    always_comb begin
        ball_valid_d    = rel;
        ball_color_d    = rel ? c : ball_color_q;
        current_color_d = reload ? CW'(BLUE) : rel ? c : current_color_q;
        no_balls_d      = !reload && (no_balls_q || (acc && !rel));
        tray_overflow_d = !reload && (tray_overflow_q || (app && tray_full));
        tray_count_d    = reload ? '0 : (app && !tray_full) ? tray_count_q + TW'(1) : tray_count_q;
        tray_d          = reload ? '0 : tray_q;
        for (int k = 0; k < TRAY_DEPTH; k++)
            if (app && !tray_full && tray_count_q == TW'(k)) tray_d[k*CW +: CW] = current_color_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ball_valid_q    <= 1'b0;
            ball_color_q    <= '0;
            current_color_q <= CW'(BLUE);
            no_balls_q      <= 1'b0;
            tray_overflow_q <= 1'b0;
            tray_count_q    <= '0;
            tray_q          <= '0;
        end else begin
            ball_valid_q    <= ball_valid_d;
            ball_color_q    <= ball_color_d;
            current_color_q <= current_color_d;
            no_balls_q      <= no_balls_d;
            tray_overflow_q <= tray_overflow_d;
            tray_count_q    <= tray_count_d;
            tray_q          <= tray_d;
        end
    end

    assign ball_valid    = ball_valid_q;
    assign ball_color    = ball_color_q;
    assign current_color = current_color_q;
    assign no_balls      = no_balls_q;
    assign tray          = tray_q;
    assign tray_count    = tray_count_q;
    assign tray_full     = tray_count_q == TW'(TRAY_DEPTH);
    assign tray_overflow = tray_overflow_q;
endmodule

// File: doc/turing_board_gen.md
# turing_board_gen

Parametrised, clocked successor of the Turing Tumble board controller. It models everything off the cell grid:

- per-colour ball hoppers with configurable capacity and colour count;
- release of one ball per trigger lever;
- tracking of the colour currently in play;
- collection of finished balls into a bounded tray.

It sits between the bottom-of-board trigger lines and the top-of-board ball-entry lines of the cell fabric, and exposes the tray contents for readout.

## Interface
Parameters:
- NUM_COLORS, 2, number of ball colours / hoppers (2..8); colour 0 = blue, 1 = red
- BALLS_PER_COLOR, 8, initial and reload count per hopper (1..31)
- TRAY_DEPTH, 16, number of tray slots (1..64)
- CW, max(1,$clog2(NUM_COLORS)), derived colour-index width; not to be overridden

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- trigger  in  NUM_COLORS  one-cycle pulse per lever; bit c requests a colour-c ball
- reload  in  1  one-cycle pulse; refill all hoppers and clear tray without full reset
- ball_valid  out  1  one-cycle pulse: a ball enters the board
- ball_color  out  CW  colour of the released ball; valid with ball_valid
- current_color  out  CW  colour of the ball on the board
- no_balls  out  1  sticky: a trigger hit an empty hopper; board halted
- tray  out  TRAY_DEPTH*CW  slot k at bits [k*CW +: CW]
- tray_count  out  $clog2(TRAY_DEPTH+1)  occupied slots
- tray_full  out  1  tray_count == TRAY_DEPTH
- tray_overflow  out  1  sticky: a ball was dropped because the tray was full

## Operation
- States:
  - START: no ball on board yet.
  - RUN: a ball is on the board.
  - HALT: entered on an empty-hopper trigger.
- Trigger selection: the accepted colour c is the lowest set index of trigger. Other set bits in the same cycle are ignored and not queued.
- Trigger accepted in START or RUN:
  - If hopper[c] > 0: decrement hopper[c], current_color <= c, pulse ball_valid with ball_color = c.
  - Else: no_balls <= 1, state <= HALT, no ball_valid. current_color and hoppers are unchanged.
- Tray append:
  - Happens on every accepted trigger in RUN, including one that leads to HALT.
  - The previous current_color (the ball just finished) is written to tray[tray_count] and tray_count is incremented.
  - START does not append.
  - After a successful release, START -> RUN.
- Tray full: no write and no increment; tray_overflow <= 1. Slots never wrap or overwrite.
- HALT: all triggers are ignored. The only exits are reload or rst.
- Reload and rst set identical state:
  - every hopper = BALLS_PER_COLOR;
  - state = START;
  - tray contents = 0, tray_count = 0;
  - no_balls = 0, tray_overflow = 0, current_color = 0.
- rst has priority over reload. reload has priority over trigger in the same cycle (the trigger is dropped).
- Hopper counters saturate at 0 and never underflow.

## Timing
- Reset values: ball_valid = 0, ball_color = 0, current_color = 0, no_balls = 0, tray = 0, tray_count = 0, tray_full = 0, tray_overflow = 0.
- Latency: trigger sampled at edge N. ball_valid, ball_color, current_color, no_balls, tray and tray_count all update at edge N (visible in cycle N+1). All outputs are registered.
- ball_valid lasts exactly one cycle per accepted trigger.
- tray_full is combinational from tray_count only.
- Back-to-back triggers on consecutive cycles are legal; each is processed independently.
- A trigger held high for k cycles counts as k triggers. Edge detection is the driver's job.

## Structure
- Package turing_board_pkg:
  - BLUE = 0, RED = 1 colour constants;
  - state enum {START, RUN, HALT};
  - priority-encode function (lowest set bit -> index, plus found flag).
- Sub-module turing_hopper: one per colour via generate.
  - Holds a 5-bit down-counter with load, dec and empty.
  - Parameter BALLS_PER_COLOR.
- Tray storage and FSM live in the top.

## Test plan
- Default params, rst, then trigger = 01 ×3:
  - ball_valid ×3, ball_color = 0;
  - hopper[0] = 5;
  - tray_count = 2, tray[0] = tray[1] = 0.
- Simultaneous trigger = 11 after rst:
  - blue released, red hopper stays 8;
  - current_color = 0, tray_count = 0.
- Nine blue triggers with BALLS_PER_COLOR = 8:
  - 9th gives no ball_valid;
  - no_balls = 1, tray_count = 8;
  - further red triggers ignored.
- TRAY_DEPTH = 4, alternate red/blue ×6:
  - tray = {1,0,1,0} from slot 0;
  - tray_full = 1, tray_overflow = 1 after 6th trigger.
- Mid-run reload concurrent with trigger = 10:
  - no ball; hoppers = 8/8;
  - tray_count = 0, state START;
  - next trigger does not append.
- NUM_COLORS = 5, trigger bit 4 after rst:
  - ball_color = 4, current_color = 4;
  - rst mid-run restores all reset values next cycle.
